fir_tcdm_mux: RTL

Downstream stage of the FIR accelerator wrapper: takes the `NB_IN` flat TCDM master ports the FIR top exposes and merges them onto a single TCDM master port toward the cluster interconnect. It arbitrates requests round-robin. It records the issuing port of every granted request in an in-order ID FIFO and routes each memory response back to that port. It bounds the number of outstanding transactions and flags protocol violations.

---
 rtl/fir_tcdm_mux.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fir_tcdm_mux.sv
// fir_tcdm_mux: merges NB_IN upstream TCDM master ports onto one downstream
// TCDM master port. Requests are arbitrated round-robin. The issuing port of
// each granted request is queued in an in-order ID FIFO, and each response is
// routed back to that port. Outstanding transactions are bounded by MAX_OUTST.
// A response that arrives with nothing outstanding sets a sticky error flag.
module fir_tcdm_mux #(
  parameter int NB_IN     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  // upstream ports
  input  logic [NB_IN-1:0]                     in_req,
  output logic [NB_IN-1:0]                     in_gnt,
  input  logic [NB_IN-1:0][ADDR_W-1:0]         in_add,
  input  logic [NB_IN-1:0]                     in_wen,
  input  logic [NB_IN-1:0][DATA_W/8-1:0]       in_be,
  input  logic [NB_IN-1:0][DATA_W-1:0]         in_data,
  output logic [NB_IN-1:0][DATA_W-1:0]         in_r_data,
  output logic [NB_IN-1:0]                     in_r_valid,
  // downstream port
  output logic                                 out_req,
  input  logic                                 out_gnt,
  output logic [ADDR_W-1:0]                    out_add,
  output logic                                 out_wen,
  output logic [DATA_W/8-1:0]                  out_be,
  output logic [DATA_W-1:0]                    out_data,
  input  logic [DATA_W-1:0]                    out_r_data,
  input  logic                                 out_r_valid,
  // status
  output logic [$clog2(MAX_OUTST):0]           outst_o,
  output logic                                 err_o
);

  localparam int IDW = $clog2(NB_IN);
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] r_rr;
  logic [IDW-1:0] r_fifo [MAX_OUTST];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_cnt;
  logic           r_err;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_head;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_spur;

  // Round-robin scan: first requesting port starting at r_rr, wrapping at NB_IN
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NB_IN; k++) begin
      w_sum = {1'b0, r_rr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NB_IN)) begin
        w_sum = w_sum - (IDW+1)'(NB_IN);
      end
      if (!w_found && in_req[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDW-1:0];
      end
    end
  end

  // A full FIFO blocks new grants even if a pop happens in the same cycle,
  // so occupancy can never exceed MAX_OUTST.
  assign w_full  = (r_cnt == CW'(MAX_OUTST));
  assign out_req = !rst_i && w_found && !w_full;
  assign w_push  = out_req && out_gnt;
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_pop   = !rst_i && out_r_valid && (r_cnt != '0);
  assign w_spur  = out_r_valid && (r_cnt == '0);

  // Payload mux; port 0 is driven when there is no request so the fields stay defined
  assign w_sel    = out_req ? w_win : '0;
  assign out_add  = in_add[w_sel];
  assign out_wen  = in_wen[w_sel];
  assign out_be   = in_be[w_sel];
  assign out_data = in_data[w_sel];

  generate
    for (genvar gi = 0; gi < NB_IN; gi++) begin : g_port
      assign in_gnt[gi]     = w_push && (w_win == IDW'(gi));
      assign in_r_valid[gi] = w_pop && (w_head == IDW'(gi));
      assign in_r_data[gi]  = out_r_data;
    end
  endgenerate

  assign outst_o = r_cnt;
  assign err_o   = r_err;

  // ID FIFO storage: records the issuing port of each granted request
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_win;
    end
  end

  // Arbitration pointer, FIFO pointers and count, and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr     <= (w_win == IDW'(NB_IN - 1)) ? '0 : w_win + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_spur) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
